// File: rtl/logicop_unit_pkg.sv
// Shared types for the execute-stage logic/shift unit: decoder op codes,
// FSM states and the shift-amount width helper.
package logicop_unit_pkg;

    typedef enum logic [2:0] {
        LOP_NOP = 3'd0,
        LOP_SLL = 3'd1,
        LOP_SRL = 3'd2,
        LOP_SRA = 3'd3,
        LOP_XOR = 3'd4,
        LOP_ORR = 3'd5,
        LOP_AND = 3'd6
    } rv32_logicop;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rv_logicop_state_e;

    function automatic int LOGICOP_SHAMT_W(input int xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/logicop_shift_step.sv
// One combinational step of the iterative shifter. In word mode only the low
// 32 bits take part and the upper half is cleared; extension happens later.
module logicop_shift_step #(
    parameter int XLEN  = 32,
    parameter int AMT_W = 3
) (
    input  logic [XLEN-1:0]  i_data,
    input  logic [AMT_W-1:0] i_amt,
    input  logic             i_left,
    input  logic             i_arith,
    input  logic             i_word,
    output logic [XLEN-1:0]  o_data
);

    logic [XLEN-1:0] full_res;

    always_comb begin
        if (i_left) begin
            full_res = i_data << i_amt;
        end else if (i_arith) begin
            full_res = XLEN'($signed(i_data) >>> i_amt);
        end else begin
            full_res = i_data >> i_amt;
        end
    end

    generate
        if (XLEN == 64) begin : g_word
            logic [31:0] lo;
            logic [31:0] lo_res;

            always_comb begin
                lo = i_data[31:0];
                if (i_left) begin
                    lo_res = lo << i_amt;
                end else if (i_arith) begin
                    lo_res = 32'($signed(lo) >>> i_amt);
                end else begin
                    lo_res = lo >> i_amt;
                end
            end

            assign o_data = i_word ? {32'b0, lo_res} : full_res;
        end else begin : g_xlen
            logic unused_word;
            assign unused_word = i_word;
            assign o_data      = full_res;
        end
    endgenerate

endmodule

// File: rtl/logicop_unit.sv
// Execute-stage logic/shift unit with valid/ready on both sides, flush,
// and an iterative shifter moving SHIFT_STEP bits per cycle.
//
// state | meaning
// IDLE  | no operation held, ready for a new one
// SHIFT | iterating a shift, remaining amount in rem_q
// DONE  | result valid on o_result until downstream takes it
module logicop_unit
    import logicop_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  rv32_logicop     i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_word,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int SHW   = LOGICOP_SHAMT_W(XLEN);
    localparam int REM_W = SHW + 1;
    localparam int AMT_W = $clog2(SHIFT_STEP) + 1;

    rv_logicop_state_e state_q, state_d;
    rv32_logicop       op_q, op_d;
    logic              word_q, word_d;
    logic [SHW-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]   work_q, work_d;

    logic              accept;
    logic              in_word;
    logic              in_shift;
    logic [SHW-1:0]    in_shamt;
    logic [XLEN-1:0]   in_result;
    logic [REM_W-1:0]  rem_ext;
    logic [AMT_W-1:0]  step_amt;
    logic [SHW-1:0]    rem_next;
    logic [XLEN-1:0]   step_out;

    // Decode of the incoming operation; only used on the accept edge.
    always_comb begin
        in_word  = (XLEN == 64) && i_word;
        in_shamt = i_b[SHW-1:0];
        if (in_word) begin
            in_shamt = SHW'(i_b[4:0]);
        end
        in_shift = (i_op == LOP_SLL) || (i_op == LOP_SRL) || (i_op == LOP_SRA);
        case (i_op)
            LOP_XOR: in_result = i_a ^ i_b;
            LOP_ORR: in_result = i_a | i_b;
            LOP_AND: in_result = i_a & i_b;
            LOP_SLL, LOP_SRL, LOP_SRA:
                in_result = in_word ? XLEN'($signed(i_a[31:0])) : i_a;
            default: in_result = '0;
        endcase
    end

    always_comb begin
        rem_ext = {1'b0, rem_q};
        if (rem_ext >= REM_W'(SHIFT_STEP)) begin
            step_amt = AMT_W'(SHIFT_STEP);
        end else begin
            step_amt = AMT_W'(rem_q);
        end
        rem_next = rem_q - SHW'(step_amt);
    end

    logicop_shift_step #(
        .XLEN  (XLEN),
        .AMT_W (AMT_W)
    ) u_shift_step (
        .i_data  (work_q),
        .i_amt   (step_amt),
        .i_left  (op_q == LOP_SLL),
        .i_arith (op_q == LOP_SRA),
        .i_word  (word_q),
        .o_data  (step_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        word_d  = word_q;
        rem_d   = rem_q;
        work_d  = work_q;
        o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
        accept  = i_valid && o_ready && !i_flush;

        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if ((state_q == DONE) && i_ready) begin
                        state_d = IDLE;
                    end
                    if (accept) begin
                        op_d   = i_op;
                        word_d = in_word;
                        rem_d  = in_shamt;
                        if (in_shift && (in_shamt != '0)) begin
                            state_d = SHIFT;
                            work_d  = i_a;
                        end else begin
                            state_d = DONE;
                            work_d  = in_result;
                        end
                    end
                end
                SHIFT: begin
                    work_d = step_out;
                    rem_d  = rem_next;
                    if (rem_next == '0) begin
                        state_d = DONE;
                        // Word results are sign-extended only once, on the final step.
                        if (word_q) begin
                            work_d = XLEN'($signed(step_out[31:0]));
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            op_q    <= LOP_NOP;
            word_q  <= 1'b0;
            rem_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            word_q  <= word_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
        end
    end

    assign o_valid  = (state_q == DONE);
    assign o_busy   = (state_q != IDLE);
    assign o_result = work_q;

endmodule
